// File: rtl/multi_channel_capture_timer.sv
// multi_channel_capture_timer
// Prescaled up-counter with start/stop/clear control and NUM_CH independent
// capture registers. Each channel has a valid/ack handshake and a sticky
// overrun flag for a value overwritten before it was acknowledged.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | counter, prescaler, flags and captures held at zero
// RUNNING | prescaler advances; counter increments on each tick
// STOPPED | counter frozen; captures still accepted
module multi_channel_capture_timer #(
  parameter int CNT_WIDTH      = 32,
  parameter int NUM_CH         = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic                          stop_in,
  input  logic                          clear_in,
  input  logic [NUM_CH-1:0]             capture_in,
  input  logic [NUM_CH-1:0]             capture_ack_in,
  input  logic [PRESCALE_WIDTH-1:0]     prescale_in,
  output logic [CNT_WIDTH-1:0]          counter_out,
  output logic [NUM_CH*CNT_WIDTH-1:0]   captured_out,
  output logic [NUM_CH-1:0]             capture_valid_out,
  output logic [NUM_CH-1:0]             overrun_out,
  output logic                          overflow_out,
  output logic                          running_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]      CNT_ONE = 1;
  localparam logic [PRESCALE_WIDTH-1:0] PSC_ONE = 1;

  state_t state_q, state_d;

  logic                start_prev_q, stop_prev_q, clear_prev_q;
  logic [NUM_CH-1:0]   cap_prev_q;
  logic                start_edge, stop_edge, clear_edge;
  logic [NUM_CH-1:0]   cap_edge;
  logic                start_accept;
  logic                tick;

  logic [CNT_WIDTH-1:0]                cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0]           psc_q, psc_d;
  logic                                ovf_q, ovf_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    cap_q, cap_d;
  logic [NUM_CH-1:0]                   valid_q, valid_d;
  logic [NUM_CH-1:0]                   ovr_q, ovr_d;

  assign start_edge = start_in & ~start_prev_q;
  assign stop_edge  = stop_in  & ~stop_prev_q;
  assign clear_edge = clear_in & ~clear_prev_q;
  assign cap_edge   = capture_in & ~cap_prev_q;

  // A start edge only matters outside RUNNING; clear overrides it.
  assign start_accept = start_edge & ~clear_edge & (state_q != RUNNING);

  // Tick compares against the live prescale_in so a new divisor applies at once.
  assign tick = (state_q == RUNNING) && (psc_q == prescale_in);

  // Edge-detect history for all level inputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      clear_prev_q <= 1'b0;
      cap_prev_q   <= '0;
    end else begin
      start_prev_q <= start_in;
      stop_prev_q  <= stop_in;
      clear_prev_q <= clear_in;
      cap_prev_q   <= capture_in;
    end
  end

  // Control state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state with priority clear > stop > start.
  always_comb begin
    state_d = state_q;
    if (clear_edge) begin
      state_d = IDLE;
    end else if (stop_edge && (state_q == RUNNING)) begin
      state_d = STOPPED;
    end else if (start_accept) begin
      state_d = RUNNING;
    end
  end

  // Counter, prescaler and per-channel capture/handshake next values.
  always_comb begin
    cnt_d   = cnt_q;
    psc_d   = psc_q;
    ovf_d   = ovf_q;
    cap_d   = cap_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clear_edge) begin
      cnt_d   = '0;
      psc_d   = '0;
      ovf_d   = 1'b0;
      cap_d   = '0;
      valid_d = '0;
      ovr_d   = '0;
    end else begin
      if (state_q == RUNNING) begin
        if (tick) begin
          psc_d = '0;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == '1) begin
            ovf_d = 1'b1;
          end
        end else begin
          psc_d = psc_q + PSC_ONE;
        end
      end
      if (start_accept) begin
        psc_d = '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_edge[i] && (state_q != IDLE)) begin
          // Captured value is the count held before this edge.
          cap_d[i]   = cnt_q;
          valid_d[i] = 1'b1;
          if (valid_q[i] && !capture_ack_in[i]) begin
            ovr_d[i] = 1'b1;
          end
        end else if (valid_q[i] && capture_ack_in[i]) begin
          valid_d[i] = 1'b0;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q   <= '0;
      psc_q   <= '0;
      ovf_q   <= 1'b0;
      cap_q   <= '0;
      valid_q <= '0;
      ovr_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      psc_q   <= psc_d;
      ovf_q   <= ovf_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign counter_out       = cnt_q;
  assign captured_out      = cap_q;
  assign capture_valid_out = valid_q;
  assign overrun_out       = ovr_q;
  assign overflow_out      = ovf_q;
  assign running_out       = (state_q == RUNNING);

endmodule

// File: tb/tb_multi_channel_capture_timer.sv
// Bench for multi_channel_capture_timer: directed scenarios with literal
// expectations, then randomized levels checked each cycle against a
// behavioural model of the timer.
module tb_multi_channel_capture_timer;

  localparam int CW   = 8;
  localparam int NC   = 4;
  localparam int PW   = 8;
  localparam int CMOD = 1 << CW;
  localparam int PMOD = 1 << PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, stop, clr;
  logic [NC-1:0]     cap, ack;
  logic [PW-1:0]     psc;
  logic [CW-1:0]     counter_out;
  logic [NC*CW-1:0]  captured_out;
  logic [NC-1:0]     capture_valid_out, overrun_out;
  logic              overflow_out, running_out;

  multi_channel_capture_timer #(
    .CNT_WIDTH(CW), .NUM_CH(NC), .PRESCALE_WIDTH(PW)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .stop_in(stop),
    .clear_in(clr), .capture_in(cap), .capture_ack_in(ack),
    .prescale_in(psc), .counter_out(counter_out),
    .captured_out(captured_out), .capture_valid_out(capture_valid_out),
    .overrun_out(overrun_out), .overflow_out(overflow_out),
    .running_out(running_out)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 idle, 1 running, 2 stopped.
  int          m_mode;
  int          m_cnt, m_phase;
  bit          m_ovf;
  int          m_cap [NC];
  bit [NC-1:0] m_val, m_ovr;
  bit          h_start, h_stop, h_clr;
  bit [NC-1:0] h_cap;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_phase = 0; m_ovf = 0;
    for (int i = 0; i < NC; i++) m_cap[i] = 0;
    m_val = '0; m_ovr = '0;
  endtask

  task automatic model_step();
    bit r_start, r_stop, r_clr;
    bit [NC-1:0] r_cap;
    if (rst) begin
      model_reset();
      h_start = 0; h_stop = 0; h_clr = 0; h_cap = '0;
      return;
    end
    r_start = start && !h_start;
    r_stop  = stop && !h_stop;
    r_clr   = clr && !h_clr;
    r_cap   = cap & ~h_cap;
    if (r_clr) begin
      model_reset();
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (m_mode != 0 && r_cap[i]) begin
          if (m_val[i] && !ack[i]) m_ovr[i] = 1;
          m_cap[i] = m_cnt;
          m_val[i] = 1;
        end else if (m_val[i] && ack[i]) begin
          m_val[i] = 0;
        end
      end
      if (m_mode == 1) begin
        if (m_phase == int'(psc)) begin
          m_phase = 0;
          if (m_cnt == CMOD - 1) m_ovf = 1;
          m_cnt = (m_cnt + 1) % CMOD;
        end else begin
          m_phase = (m_phase + 1) % PMOD;
        end
      end
      if (r_stop && m_mode == 1) begin
        m_mode = 2;
      end else if (r_start && m_mode != 1) begin
        m_mode = 1;
        m_phase = 0;
      end
    end
    h_start = start; h_stop = stop; h_clr = clr; h_cap = cap;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    check("counter", counter_out, m_cnt);
    for (int i = 0; i < NC; i++)
      check($sformatf("captured[%0d]", i), captured_out[i*CW +: CW], m_cap[i]);
    check("valid", capture_valid_out, m_val);
    check("overrun", overrun_out, m_ovr);
    check("overflow", overflow_out, m_ovf);
    check("running", running_out, m_mode == 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_clear();
    clr = 1; cycle();
    clr = 0; cycle();
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; clr = 0; cap = '0; ack = '0; psc = '0;
    model_reset();
    h_start = 0; h_stop = 0; h_clr = 0; h_cap = '0;
    cycle();
    check("reset_counter", counter_out, 0);
    check("reset_running", running_out, 0);
    rst = 0; cycle();

    // Basic capture, prescale 0
    psc = 0; start = 1; cycle(); start = 0;
    run(9);
    cap[0] = 1; cycle(); cap[0] = 0;
    check("basic_captured0", captured_out[0 +: CW], 9);
    check("basic_valid0", capture_valid_out[0], 1);
    check("basic_running", running_out, 1);
    do_clear();

    // Prescaler divide-by-4
    psc = 3; start = 1; cycle(); start = 0;
    run(40);
    check("prescale_counter", counter_out, 10);
    do_clear();

    // Overflow
    psc = 0; start = 1; cycle(); start = 0;
    run(255);
    check("ovf_pre_count", counter_out, 255);
    check("ovf_pre_flag", overflow_out, 0);
    cycle();
    check("ovf_wrap_count", counter_out, 0);
    check("ovf_wrap_flag", overflow_out, 1);
    run(5);
    check("ovf_sticky", overflow_out, 1);
    clr = 1; cycle(); clr = 0;
    check("ovf_cleared", overflow_out, 0);
    check("ovf_clear_count", counter_out, 0);
    cycle();

    // Handshake and overrun
    start = 1; cycle(); start = 0;
    run(4);
    cap[1] = 1; cycle(); cap[1] = 0;
    check("hs_cap1_first", captured_out[1*CW +: CW], 4);
    check("hs_ovr1_first", overrun_out[1], 0);
    cycle();
    cap[1] = 1; cycle(); cap[1] = 0;
    check("hs_cap1_second", captured_out[1*CW +: CW], 6);
    check("hs_ovr1_set", overrun_out[1], 1);
    check("hs_valid1", capture_valid_out[1], 1);
    cap[2] = 1; cycle(); cap[2] = 0;
    check("hs_cap2_first", captured_out[2*CW +: CW], 7);
    cycle();
    cap[2] = 1; ack[2] = 1; cycle(); cap[2] = 0;
    check("hs_cap2_ack_same", captured_out[2*CW +: CW], 9);
    check("hs_valid2_kept", capture_valid_out[2], 1);
    check("hs_ovr2_none", overrun_out[2], 0);
    cycle();
    check("hs_valid2_acked", capture_valid_out[2], 0);
    cycle();
    check("hs_ack_idle_valid", capture_valid_out[2], 0);
    check("hs_ack_idle_ovr", overrun_out[2], 0);
    check("hs_ovr1_sticky", overrun_out[1], 1);
    ack[2] = 0;
    do_clear();

    // Stop, resume, combined clear/start/stop
    start = 1; cycle(); start = 0;
    run(5);
    cap[3] = 1; cycle(); cap[3] = 0;
    run(13);
    stop = 1; cycle(); stop = 0;
    check("stop_count", counter_out, 20);
    check("stop_running", running_out, 0);
    run(15);
    check("stopped_hold", counter_out, 20);
    start = 1; cycle(); start = 0;
    check("resume_running", running_out, 1);
    check("resume_count", counter_out, 20);
    cycle();
    check("resume_next", counter_out, 21);
    clr = 1; start = 1; stop = 1; cycle();
    check("combo_counter", counter_out, 0);
    check("combo_running", running_out, 0);
    check("combo_captured", captured_out, 0);
    check("combo_valid", capture_valid_out, 0);
    clr = 0; start = 0; stop = 0; cycle();

    // Reset mid-run with a capture pending
    start = 1; cycle(); start = 0;
    run(49);
    cap[0] = 1; cycle(); cap[0] = 0;
    run(50);
    check("pre_rst_count", counter_out, 100);
    check("pre_rst_valid", capture_valid_out[0], 1);
    rst = 1; start = 1; cycle();
    check("rst_counter", counter_out, 0);
    check("rst_valid", capture_valid_out, 0);
    check("rst_captured", captured_out, 0);
    check("rst_running", running_out, 0);
    // Start already high when reset releases counts as an edge
    rst = 0; cycle();
    check("post_rst_start_edge", running_out, 1);
    start = 0;

    // Randomized levels
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0)   start = ~start;
      if ($urandom_range(0, 15) == 0)  stop = ~stop;
      if ($urandom_range(0, 99) == 0)  clr = ~clr;
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 5) == 0) cap[i] = ~cap[i];
        ack[i] = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 63) == 0) psc = PW'($urandom_range(0, 5));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
